// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command constants for the host transmit and receive paths.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    START,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // PS/2 uses odd parity: data bits plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clock/data pads and flags falling edges of the clock.
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic clk_o,
  output logic dat_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;

  // Idle bus level is high, so the chain resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], clk_raw_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], dat_raw_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_o  = clk_sync_q[SYNC_STAGES-1];
  assign dat_o  = dat_sync_q[SYNC_STAGES-1];
  assign fall_o = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, device ack check
// and inter-edge timeout, driving open-collector lines through the *_oe outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  ps2_tx_state_t    state_q;
  logic [8:0]       shift_q;
  logic [3:0]       bitcnt_q;
  logic [INH_W-1:0] inh_q;
  logic [TMO_W-1:0] tmo_q;
  logic             clk_oe_q, dat_oe_q, busy_q, done_q, error_q;

  logic clk_s, dat_s, fall;
  logic tmo_expire;
  logic to_err;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .clk_raw_i(ps2_clk_in),
    .dat_raw_i(ps2_dat_in),
    .clk_o    (clk_s),
    .dat_o    (dat_s),
    .fall_o   (fall)
  );

  // Expire on the cycle the counter would reach zero, so the error registers
  // exactly TIMEOUT_CYCLES cycles after the reload.
  assign tmo_expire = (tmo_q == TMO_W'(1)) || (tmo_q == '0);

  always_comb begin
    to_err = 1'b0;
    unique case (state_q)
      SHIFT:     to_err = !fall && tmo_expire;
      ACK:       to_err = fall ? dat_s : tmo_expire;
      WAIT_IDLE: to_err = !(clk_s && dat_s) && !fall && tmo_expire;
      default:   to_err = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      inh_q    <= '0;
      tmo_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (to_err) begin
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        error_q  <= 1'b1;
        state_q  <= ERR;
      end else begin
        unique case (state_q)
          IDLE: if (send) begin
            shift_q  <= {odd_parity(tx_byte), tx_byte};
            inh_q    <= '0;
            bitcnt_q <= '0;
            clk_oe_q <= 1'b1;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= INHIBIT;
          end
          INHIBIT: begin
            if (inh_q == INH_LAST) begin
              dat_oe_q <= 1'b1;
              state_q  <= START;
            end else begin
              inh_q <= inh_q + INH_W'(1);
            end
          end
          START: begin
            clk_oe_q <= 1'b0;
            tmo_q    <= TMO_LOAD;
            state_q  <= RELEASE;
          end
          RELEASE: begin
            bitcnt_q <= '0;
            state_q  <= SHIFT;
          end
          SHIFT: begin
            if (fall) begin
              tmo_q    <= TMO_LOAD;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q < 4'd9) begin
                dat_oe_q <= ~shift_q[bitcnt_q];
              end else begin
                dat_oe_q <= 1'b0;
                state_q  <= ACK;
              end
            end else begin
              tmo_q <= tmo_q - TMO_W'(1);
            end
          end
          ACK: begin
            if (fall) begin
              tmo_q   <= TMO_LOAD;
              state_q <= WAIT_IDLE;
            end else begin
              tmo_q <= tmo_q - TMO_W'(1);
            end
          end
          WAIT_IDLE: begin
            if (clk_s && dat_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (fall) begin
              tmo_q <= TMO_LOAD;
            end else begin
              tmo_q <= tmo_q - TMO_W'(1);
            end
          end
          DONE:    state_q <= IDLE;
          ERR:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rx_inhibit = busy_q;

endmodule
